// File: rtl/periph_bus_initiator.sv
// periph_bus_initiator: single-outstanding valid/ready to peripheral bus bridge.
// Define PERIPH_POSTED_WRITE_EN to build the posted-write FIFO.
module periph_bus_initiator #(
  parameter int ADDR_WIDTH = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [31:0]           bus_write_data,
  output logic                  bus_we,
  output logic                  bus_re,
  input  logic [31:0]           bus_read_data
);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WR_ISSUE      = 3'd1,
    RD_WAIT_DRAIN = 3'd2,
    RD_ISSUE      = 3'd3,
    RD_CAPTURE    = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic                  req_fire;
  logic                  full_d;
  logic                  empty_d;

`ifdef PERIPH_POSTED_WRITE_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [31:0]           fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  enq;
  logic                  deq;
`endif

  assign req_fire = req_valid && req_ready_q;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    full_d      = 1'b0;
    empty_d     = 1'b1;
`ifdef PERIPH_POSTED_WRITE_EN
    enq       = 1'b0;
    deq       = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (req_we) begin
`ifdef PERIPH_POSTED_WRITE_EN
            enq = 1'b1;
`else
            state_d     = WR_ISSUE;
            we_d        = 1'b1;
            addr_d      = req_addr;
            wdata_d     = req_wdata;
            rsp_valid_d = 1'b1;
`endif
          end else begin
`ifdef PERIPH_POSTED_WRITE_EN
            rd_addr_d = req_addr;
            if (cnt_q != '0) begin
              state_d = RD_WAIT_DRAIN;
            end else begin
              state_d = RD_ISSUE;
              re_d    = 1'b1;
              addr_d  = req_addr;
            end
`else
            state_d = RD_ISSUE;
            re_d    = 1'b1;
            addr_d  = req_addr;
`endif
          end
        end
      end
      WR_ISSUE: state_d = IDLE;
`ifdef PERIPH_POSTED_WRITE_EN
      // Wait one extra cycle after the last pop so strobes never overlap.
      RD_WAIT_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = RD_ISSUE;
          re_d    = 1'b1;
          addr_d  = rd_addr_q;
        end
      end
`endif
      RD_ISSUE: begin
        state_d     = RD_CAPTURE;
        rsp_valid_d = 1'b1;
      end
      RD_CAPTURE: begin
        state_d = IDLE;
        rdata_d = bus_read_data;
      end
      default: state_d = IDLE;
    endcase
`ifdef PERIPH_POSTED_WRITE_EN
    deq = (cnt_q != '0);
    if (deq) begin
      we_d     = 1'b1;
      addr_d   = fifo_addr_q[rd_ptr_q];
      wdata_d  = fifo_data_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (enq) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    cnt_d   = cnt_q + (PW+1)'(enq) - (PW+1)'(deq);
    full_d  = (cnt_d == (PW+1)'(FIFO_DEPTH));
    empty_d = (cnt_d == '0);
`endif
    req_ready_d = (state_d == IDLE) && !full_d;
    busy_d      = (state_d != IDLE) || !empty_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
    end
  end

`ifdef PERIPH_POSTED_WRITE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_addr_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr_q[wr_ptr_q] <= req_addr;
      fifo_data_q[wr_ptr_q] <= req_wdata;
    end
  end
`endif

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign busy           = busy_q;
  assign bus_address    = addr_q;
  assign bus_write_data = wdata_q;
  assign bus_we         = we_q;
  assign bus_re         = re_q;
  // Decoder read data is already a flop; forward it in the capture cycle.
  assign rsp_rdata = (state_q == RD_CAPTURE) ? bus_read_data : rdata_q;

endmodule
